// File: rtl/conv_encoder_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_encoder_stream                                          |
// | Description : Rate-1/N, constraint-length-K feedforward convolutional      |
// |               encoder with frame control and zero-tail termination.        |
// |               One information bit per input handshake, one N-bit code      |
// |               word per bit through a single registered valid/ready stage,  |
// |               followed by K-1 tail words that return the encoder to 0.     |
// | Optional    : CONV_ENC_PUNCTURE_EN adds parameter P, input i_punct_mask    |
// |               and output o_out_mask (per-word puncture mask, period P).    |
// | Ports       : clk, rst (sync, active-low)                                  |
// |               i_gen_poly  [N][K] generator polynomials (bit k = delay k)   |
// |               i_frame_len information bits per frame                       |
// |               i_start     frame start request (sampled in IDLE only)       |
// |               i_in_valid/i_in_bit/o_in_ready  information bit handshake    |
// |               o_out_valid/o_out_data/i_out_ready  code word handshake      |
// |               o_busy      frame in progress                                |
// |               o_done      one-cycle pulse after the last tail word         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module conv_encoder_stream #(
  parameter int K     = 7,
  parameter int N     = 2,
  parameter int LEN_W = 16
`ifdef CONV_ENC_PUNCTURE_EN
  ,
  parameter int P     = 2
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0][K-1:0]   i_gen_poly,
  input  logic [LEN_W-1:0]      i_frame_len,
  input  logic                  i_start,
  input  logic                  i_in_valid,
  input  logic                  i_in_bit,
  output logic                  o_in_ready,
  output logic                  o_out_valid,
  output logic [N-1:0]          o_out_data,
  input  logic                  i_out_ready,
`ifdef CONV_ENC_PUNCTURE_EN
  input  logic [P-1:0][N-1:0]   i_punct_mask,
  output logic [N-1:0]          o_out_mask,
`endif
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int c_TAIL_W = (K > 2) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_TAIL  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [K-2:0]          r_sr;
  logic [N-1:0][K-1:0]   r_poly;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_bit_cnt;
  logic [c_TAIL_W-1:0]   r_tail_cnt;
  logic                  r_out_valid;
  logic [N-1:0]          r_out_data;
  logic                  r_done;

  logic                  w_free;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_tail_enc;
  logic                  w_encode;
  logic                  w_bit;
  logic                  w_done_nxt;
  logic [K-1:0]          w_vec;
  logic [N-1:0]          w_code;

  // The output register can take a new word when it is empty or being drained.
  assign w_free   = !r_out_valid || i_out_ready;
  assign w_encode = w_accept || w_tail_enc;
  // Tail words encode a forced zero.
  assign w_bit    = w_accept && i_in_bit;
  assign w_vec    = {r_sr, w_bit};

  always_comb begin
    w_code = '0;
    for (int i = 0; i < N; i++) begin
      w_code[i] = ^(w_vec & r_poly[i]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    w_accept    = 1'b0;
    w_tail_enc  = 1'b0;
    w_start     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_start     = 1'b1;
          w_state_nxt = (i_frame_len != '0) ? S_DATA : S_TAIL;
        end
      end
      S_DATA: begin
        o_in_ready = w_free;
        w_accept   = i_in_valid && w_free;
        if (w_accept && (r_bit_cnt == r_len - LEN_W'(1))) begin
          w_state_nxt = S_TAIL;
        end
      end
      S_TAIL: begin
        w_tail_enc = w_free;
        if (w_free && (r_tail_cnt == c_TAIL_W'(K - 2))) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Last tail word is accepted on this edge when free is high.
        if (w_free) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_poly      <= '0;
      r_len       <= '0;
      r_bit_cnt   <= '0;
      r_tail_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_start) begin
        r_sr       <= '0;
        r_bit_cnt  <= '0;
        r_tail_cnt <= '0;
        r_poly     <= i_gen_poly;
        r_len      <= i_frame_len;
      end else if (w_encode) begin
        r_sr <= w_vec[K-2:0];
        if (w_accept) begin
          r_bit_cnt <= r_bit_cnt + LEN_W'(1);
        end else begin
          r_tail_cnt <= r_tail_cnt + c_TAIL_W'(1);
        end
      end
      if (w_encode) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_code;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef CONV_ENC_PUNCTURE_EN
  localparam int c_IDX_W = (P > 1) ? $clog2(P) : 1;

  logic [P-1:0][N-1:0]   r_mask;
  logic [c_IDX_W-1:0]    r_idx;
  logic [N-1:0]          r_out_mask;

  // Mask index advances once per emitted word, so it tracks word position.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mask     <= '0;
      r_idx      <= '0;
      r_out_mask <= '0;
    end else if (w_start) begin
      r_mask <= i_punct_mask;
      r_idx  <= '0;
    end else if (w_encode) begin
      r_out_mask <= r_mask[r_idx];
      r_idx      <= (r_idx == c_IDX_W'(P - 1)) ? '0 : r_idx + c_IDX_W'(1);
    end
  end

  assign o_out_mask = r_out_mask;
`endif

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

endmodule
`default_nettype wire

// File: doc/conv_encoder_stream.md
Name: conv_encoder_stream

Overview:
- Parametrised rate-1/N, constraint-length-K feedforward convolutional encoder with frame control and zero-tail termination.
- Accepts one information bit per handshake and emits one N-bit code word per bit through a registered valid/ready output stage.
- Appends K-1 zero tail bits so the encoder ends in state 0 for the trellis decoder.
- Sits in the encode-mode path ahead of the channel/memory writer and replaces the single-rate fixed-width encoder.

Parameters:
- K, 7, constraint length (shift register holds K-1 bits); legal range 3..9
- N, 2, code outputs per input bit (rate 1/N); legal range 2..4
- LEN_W, 16, width of the frame-length field

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset; sampled on posedge clk, 0 = reset
- i_gen_poly  in  [K-1:0] x N  generator polynomials; bit k taps the bit delayed by k (bit 0 = current input)
- i_frame_len  in  LEN_W  number of information bits in the frame
- i_start  in  1  single-cycle frame start request
- i_in_valid  in  1  information bit valid
- i_in_bit  in  1  information bit
- o_in_ready  out  1  encoder accepts i_in_bit this cycle
- o_out_valid  out  1  code word valid
- o_out_data  out  N  code word; bit i = output of polynomial i
- i_out_ready  in  1  downstream accepts the code word
- o_busy  out  1  frame in progress (state != IDLE)
- o_done  out  1  one-cycle pulse after the last tail word is accepted

Behaviour:
- Reset (rst=0 at posedge):
  - state = IDLE; shift register = 0; bit/tail counters = 0.
  - o_out_valid = 0, o_out_data = 0, o_in_ready = 0, o_busy = 0, o_done = 0.
  - Reset mid-frame aborts the frame; no further words are emitted.
- Encode function: vec = {sr[K-2:0], b}; out[i] = XOR over k of (vec[k] & gen_poly[i][k]). After each encoded bit, sr <= {sr[K-3:0], b}.
- Polynomials and frame length are latched on the accepted start. Changes to i_gen_poly or i_frame_len mid-frame have no effect.
- Output stage: a single register. Define free = !o_out_valid || i_out_ready.
  - On an encode event, o_out_data and o_out_valid=1 load on the same edge (1-cycle latency from bit acceptance).
  - o_out_valid and o_out_data hold stable while i_out_ready = 0.
  - o_out_valid clears when the word is accepted and no new word loads.
- FSM:
  - IDLE: i_start=1 -> clear sr and counters, latch config. Go to DATA if frame_len > 0, else go to TAIL.
  - DATA: o_in_ready = free (combinational). A bit is accepted on i_in_valid & o_in_ready. After frame_len accepted bits -> TAIL.
  - TAIL: when free, encode b=0 (one tail word per free cycle, no input handshake). After K-1 tail words -> FLUSH. o_in_ready = 0.
  - FLUSH: wait for the last word to be accepted (o_out_valid=0 or i_out_ready=1). Then pulse o_done=1 for one cycle and return to IDLE.
- o_in_ready = 0 outside DATA. i_start outside IDLE is ignored.
- Full throughput: one word per cycle when i_in_valid = i_out_ready = 1 continuously.
- Total words per frame = frame_len + K-1. sr = 0 at o_done.

Optional Feature:
- Macro: CONV_ENC_PUNCTURE_EN.
- When defined:
  - Adds parameter P (default 2, puncture period).
  - Adds input i_punct_mask [N-1:0] x P (latched at start).
  - Adds output o_out_mask [N-1:0] = mask[idx], registered with o_out_data (reset 0).
  - idx increments per emitted word, wraps P-1 -> 0, and clears at start.
  - Words with an all-zero mask are still emitted; the downstream writer drops masked bits.
- When undefined: no mask ports; all N bits are always valid.

Test Plan:
- K=3, N=2, polys 3'b111/3'b101, frame_len=4, bits 1,0,1,1, i_out_ready=1 -> o_out_data sequence 2'b11,01,00,10,10,11; then o_done pulses one cycle; o_in_ready low throughout TAIL.
- Same frame with i_out_ready toggling 1,0,0,1 repeatedly -> o_out_data holds while stalled; o_in_ready=0 while the word is held and not accepted; identical word sequence; no words lost or duplicated.
- frame_len=0, start -> exactly K-1=2 words of 00; then o_done; o_in_ready never asserts.
- rst=0 asserted after 2 data words -> next cycle all outputs 0, IDLE. A new start with bits 1,1 -> first word 2'b11 (sr cleared).
- i_start pulsed during DATA, and i_gen_poly changed mid-frame -> both ignored; output matches the first test.
- CONV_ENC_PUNCTURE_EN, P=2, masks {2'b11, 2'b01}, frame_len=4 -> o_out_mask sequence 11,01,11,01,11,01.
